gate_array_filt: RTL and testbench

GATE_ARRAY_FILT -- requirements
Module: gate_array_filt

---
 rtl/gate_array_filt.sv | 104 ++++++++++
 tb/tb_gate_array_filt.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_array_filt.sv
// gate_array_filt: per-channel 2-input gate (OR/AND/XOR/NOR) with o_Y persistence filter when GATE_ARRAY_FILT_FILTER_EN is defined.
// Latency FILTER_CYC edges (filtered) or 1 edge (unfiltered); no backpressure, i_en=0 freezes o_Y and clears pending counts.
module gate_array_filt #(
  parameter int N_CH       = 4,
  parameter int FILTER_CYC = 3
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_en,
  input  logic [1:0]      i_mode,
  input  logic [N_CH-1:0] i_A,
  input  logic [N_CH-1:0] i_B,
  output logic [N_CH-1:0] o_Y,
  output logic [N_CH-1:0] o_chg,
  output logic            o_busy
);

  if (N_CH < 1 || N_CH > 32) begin : g_bad_n_ch
    $error("gate_array_filt: N_CH must be 1..32");
  end
  if (FILTER_CYC < 1 || FILTER_CYC > 15) begin : g_bad_filter_cyc
    $error("gate_array_filt: FILTER_CYC must be 1..15");
  end

  logic [N_CH-1:0] raw;
  logic [N_CH-1:0] y_q, y_d;
  logic [N_CH-1:0] chg_q, chg_d;

  always_comb begin
    case (i_mode)
      2'b00:   raw = i_A | i_B;
      2'b01:   raw = i_A & i_B;
      2'b10:   raw = i_A ^ i_B;
      default: raw = ~(i_A | i_B);
    endcase
  end

`ifdef GATE_ARRAY_FILT_FILTER_EN
  localparam logic [3:0] CNT_LAST = 4'(FILTER_CYC - 1);

  logic [N_CH-1:0][3:0] cnt_q, cnt_d;
  logic                 busy;

  // A result commits on the edge where the mismatch has already been seen FILTER_CYC-1 times.
  always_comb begin
    y_d   = y_q;
    chg_d = '0;
    cnt_d = cnt_q;
    for (int i = 0; i < N_CH; i++) begin
      if (!i_en || (raw[i] == y_q[i])) begin
        cnt_d[i] = 4'd0;
      end else if (cnt_q[i] == CNT_LAST) begin
        y_d[i]   = raw[i];
        chg_d[i] = 1'b1;
        cnt_d[i] = 4'd0;
      end else begin
        cnt_d[i] = cnt_q[i] + 4'd1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (cnt_q[i] != 4'd0) busy = 1'b1;
    end
  end

  assign o_busy = busy;
`else
  always_comb begin
    y_d   = y_q;
    chg_d = '0;
    if (i_en) begin
      y_d   = raw;
      chg_d = raw ^ y_q;
    end
  end

  assign o_busy = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      y_q   <= '0;
      chg_q <= '0;
    end else begin
      y_q   <= y_d;
      chg_q <= chg_d;
    end
  end

  assign o_Y   = y_q;
  assign o_chg = chg_q;

endmodule

// File: tb/tb_gate_array_filt.sv
// Bench for gate_array_filt: cycle scoreboard plus directed checks; adapts to GATE_ARRAY_FILT_FILTER_EN.
module tb_gate_array_filt;
  localparam int N  = 4;
  localparam int FC = 3;
`ifdef GATE_ARRAY_FILT_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic         i_clk   = 1'b0;
  logic         i_rst_n = 1'b1;
  logic         i_en    = 1'b0;
  logic [1:0]   i_mode  = 2'b00;
  logic [N-1:0] i_A     = '0;
  logic [N-1:0] i_B     = '0;
  logic [N-1:0] o_Y, o_chg;
  logic         o_busy;

  typedef struct packed {
    logic [N-1:0] y;
    logic [N-1:0] chg;
    logic         busy;
  } exp_t;

  exp_t         sb[$];
  exp_t         e;
  logic [N-1:0] m_y, m_chg;
  int           m_cnt[N];
  int           tests_run = 0;
  int           failures  = 0;

  gate_array_filt #(.N_CH(N), .FILTER_CYC(FC)) dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_en   (i_en),
    .i_mode (i_mode),
    .i_A    (i_A),
    .i_B    (i_B),
    .o_Y    (o_Y),
    .o_chg  (o_chg),
    .o_busy (o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic model_reset();
    m_y   = '0;
    m_chg = '0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    sb.delete();
  endtask

  // Predict the outputs after the coming edge from the inputs currently driven.
  task automatic model_push();
    logic [N-1:0] r;
    logic         busy;
    exp_t         x;
    case (i_mode)
      2'b00:   r = i_A | i_B;
      2'b01:   r = i_A & i_B;
      2'b10:   r = i_A ^ i_B;
      default: r = ~(i_A | i_B);
    endcase
    for (int i = 0; i < N; i++) begin
      m_chg[i] = 1'b0;
      if (!i_en) begin
        m_cnt[i] = 0;
      end else if (!FILT) begin
        m_chg[i] = r[i] ^ m_y[i];
        m_y[i]   = r[i];
      end else if (r[i] == m_y[i]) begin
        m_cnt[i] = 0;
      end else if (m_cnt[i] == FC - 1) begin
        m_y[i]   = r[i];
        m_chg[i] = 1'b1;
        m_cnt[i] = 0;
      end else begin
        m_cnt[i] = m_cnt[i] + 1;
      end
    end
    busy = 1'b0;
    for (int i = 0; i < N; i++) if (m_cnt[i] != 0) busy = 1'b1;
    x.y = m_y; x.chg = m_chg; x.busy = busy;
    sb.push_back(x);
  endtask

  task automatic cycle();
    model_push();
    @(posedge i_clk);
    #1;
    e = (sb.size() != 0) ? sb.pop_front() : '0;
  endtask

  task automatic test_reset();
    #1 i_rst_n = 1'b0;
    #1;
    tests_run++;
    if ({o_Y, o_chg, o_busy} !== '0) begin
      failures++;
      $display("FAIL reset_async: y=%b chg=%b busy=%b, want all 0", o_Y, o_chg, o_busy);
    end
    for (int k = 0; k < 4; k++) begin
      i_en = 1'b1; i_mode = 2'($urandom_range(0, 3));
      i_A = 4'($urandom); i_B = 4'($urandom);
      @(posedge i_clk); #1;
      tests_run++;
      if ({o_Y, o_chg, o_busy} !== '0) begin
        failures++;
        $display("FAIL reset_held cyc %0d: y=%b chg=%b busy=%b, want all 0", k, o_Y, o_chg, o_busy);
      end
    end
    i_A = '0; i_B = '0; i_mode = 2'b00; i_en = 1'b1;
    i_rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_single_rise();
    i_A = 4'b0001; i_B = '0; i_mode = 2'b00;
    for (int k = 1; k <= 5; k++) begin
      cycle();
      tests_run++;
      if ({o_Y, o_chg, o_busy} !== e) begin
        failures++;
        $display("FAIL rise_sb edge k+%0d: y=%b chg=%b busy=%b, want y=%b chg=%b busy=%b",
                 k, o_Y, o_chg, o_busy, e.y, e.chg, e.busy);
      end
`ifdef GATE_ARRAY_FILT_FILTER_EN
      if (k <= 2) begin
        tests_run++;
        if (o_Y !== 4'b0000 || o_busy !== 1'b1) begin
          failures++;
          $display("FAIL rise_pending edge k+%0d: y=%b busy=%b, want y=0000 busy=1", k, o_Y, o_busy);
        end
      end else if (k == 3) begin
        tests_run++;
        if (o_Y !== 4'b0001 || o_chg !== 4'b0001) begin
          failures++;
          $display("FAIL rise_commit edge k+3: y=%b chg=%b, want y=0001 chg=0001", o_Y, o_chg);
        end
      end else if (k == 4) begin
        tests_run++;
        if (o_chg !== 4'b0000) begin
          failures++;
          $display("FAIL rise_chg_clear edge k+4: chg=%b, want 0000", o_chg);
        end
      end
`else
      tests_run++;
      if (o_Y !== 4'b0001 || o_chg !== ((k == 1) ? 4'b0001 : 4'b0000) || o_busy !== 1'b0) begin
        failures++;
        $display("FAIL rise_unfilt edge k+%0d: y=%b chg=%b busy=%b", k, o_Y, o_chg, o_busy);
      end
`endif
    end
  endtask

  task automatic test_glitch();
    for (int k = 0; k < 6; k++) begin
      i_A = (k < 2) ? 4'b0011 : 4'b0001;
      cycle();
      tests_run++;
      if ({o_Y, o_chg, o_busy} !== e) begin
        failures++;
        $display("FAIL glitch_sb cyc %0d: y=%b chg=%b busy=%b, want y=%b chg=%b busy=%b",
                 k, o_Y, o_chg, o_busy, e.y, e.chg, e.busy);
      end
`ifdef GATE_ARRAY_FILT_FILTER_EN
      tests_run++;
      if (o_Y !== 4'b0001 || o_chg !== 4'b0000 || (k >= 2 && o_busy !== 1'b0)) begin
        failures++;
        $display("FAIL glitch_filtered cyc %0d: y=%b chg=%b busy=%b, want y=0001 chg=0000", k, o_Y, o_chg, o_busy);
      end
`endif
    end
  endtask

  task automatic test_mode_sweep();
    logic [N-1:0] tab [4];
    tab[0] = 4'b1110; tab[1] = 4'b1000; tab[2] = 4'b0110; tab[3] = 4'b0001;
    i_A = '0; i_B = '0; i_mode = 2'b00;
    for (int k = 0; k < 4; k++) cycle();
    i_A = 4'b1100; i_B = 4'b1010;
    for (int m = 0; m < 4; m++) begin
      i_mode = 2'(m);
      for (int k = 0; k < 3; k++) begin
        cycle();
        tests_run++;
        if ({o_Y, o_chg, o_busy} !== e) begin
          failures++;
          $display("FAIL sweep_sb mode %0d cyc %0d: y=%b chg=%b busy=%b, want y=%b chg=%b busy=%b",
                   m, k, o_Y, o_chg, o_busy, e.y, e.chg, e.busy);
        end
      end
      tests_run++;
      if (o_Y !== tab[m]) begin
        failures++;
        $display("FAIL sweep_result mode %0d: y=%b, want %b", m, o_Y, tab[m]);
      end
    end
  endtask

  task automatic test_enable();
    logic [N-1:0] hold;
`ifdef GATE_ARRAY_FILT_FILTER_EN
    hold = 4'b0000;
`else
    hold = 4'b0001;
`endif
    i_A = '0; i_B = '0; i_mode = 2'b00; i_en = 1'b1;
    for (int k = 0; k < 4; k++) cycle();
    for (int k = 0; k < 7; k++) begin
      i_A  = 4'b0001;
      i_en = (k == 2 || k == 3) ? 1'b0 : 1'b1;
      cycle();
      tests_run++;
      if ({o_Y, o_chg, o_busy} !== e) begin
        failures++;
        $display("FAIL en_sb cyc %0d: y=%b chg=%b busy=%b, want y=%b chg=%b busy=%b",
                 k, o_Y, o_chg, o_busy, e.y, e.chg, e.busy);
      end
      if (k == 2 || k == 3) begin
        tests_run++;
        if (o_Y !== hold || o_chg !== 4'b0000 || o_busy !== 1'b0) begin
          failures++;
          $display("FAIL en_frozen cyc %0d: y=%b chg=%b busy=%b, want y=%b chg=0000 busy=0",
                   k, o_Y, o_chg, o_busy, hold);
        end
      end
`ifdef GATE_ARRAY_FILT_FILTER_EN
      if (k == 5 || k == 6) begin
        tests_run++;
        if (o_Y !== ((k == 6) ? 4'b0001 : 4'b0000)) begin
          failures++;
          $display("FAIL en_restart cyc %0d: y=%b, want %b", k, o_Y, (k == 6) ? 4'b0001 : 4'b0000);
        end
      end
`endif
    end
  endtask

  task automatic test_reset_mid();
    i_A = 4'b1111; i_B = '0; i_mode = 2'b00; i_en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cycle();
      tests_run++;
      if ({o_Y, o_chg, o_busy} !== e) begin
        failures++;
        $display("FAIL rmid_sb cyc %0d: y=%b chg=%b busy=%b, want y=%b chg=%b busy=%b",
                 k, o_Y, o_chg, o_busy, e.y, e.chg, e.busy);
      end
    end
    #3 i_rst_n = 1'b0;
    #1;
    tests_run++;
    if ({o_Y, o_chg, o_busy} !== '0) begin
      failures++;
      $display("FAIL rmid_async: y=%b chg=%b busy=%b, want all 0", o_Y, o_chg, o_busy);
    end
    model_reset();
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      cycle();
      tests_run++;
      if ({o_Y, o_chg, o_busy} !== e) begin
        failures++;
        $display("FAIL rmid_restart_sb edge %0d: y=%b chg=%b busy=%b, want y=%b chg=%b busy=%b",
                 k, o_Y, o_chg, o_busy, e.y, e.chg, e.busy);
      end
`ifdef GATE_ARRAY_FILT_FILTER_EN
      if (k == 2 || k == 3) begin
        tests_run++;
        if (o_Y !== ((k == 3) ? 4'b1111 : 4'b0000)) begin
          failures++;
          $display("FAIL rmid_restart edge %0d: y=%b, want %b", k, o_Y, (k == 3) ? 4'b1111 : 4'b0000);
        end
      end
`endif
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        i_A    = 4'($urandom);
        i_B    = 4'($urandom);
        i_mode = 2'($urandom_range(0, 3));
      end
      i_en = ($urandom_range(0, 9) != 0);
      cycle();
      tests_run++;
      if ({o_Y, o_chg, o_busy} !== e) begin
        failures++;
        $display("FAIL b2b_sb cyc %0d: y=%b chg=%b busy=%b, want y=%b chg=%b busy=%b",
                 k, o_Y, o_chg, o_busy, e.y, e.chg, e.busy);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_rise();
    test_glitch();
    test_mode_sweep();
    test_enable();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
